// File: rtl/vga_line_fetcher.sv
// Prefetches one RGB332 scanline per line period from a word-addressed framebuffer
// into a ping-pong line buffer and feeds vga_driver one pixel per clock.
module vga_line_fetcher #(
    parameter int          HPIXELS   = 640,
    parameter int          VLINES    = 480,
    parameter int          WORD_W    = 32,
    parameter int          ADDR_W    = 20,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              CLK_25MHz,
    input  logic              RESET,
    input  logic [9:0]        CURX,
    input  logic              HBLANK,
    input  logic              VBLANK,
    output logic [7:0]        COLOR_DATA_OUT,
    output logic              MEM_REQ,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic              MEM_ACK,
    input  logic [WORD_W-1:0] MEM_RDATA,
    output logic              UNDERRUN
);

    localparam int PPW  = WORD_W / 8;
    localparam int WPL  = HPIXELS / PPW;
    localparam int PSH  = $clog2(PPW);
    localparam int WIDX = $clog2(WPL);
    localparam int BIDX = $clog2(2 * WPL);
    localparam int YW   = $clog2(VLINES + 1);
    localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WPL);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [WIDX-1:0]   w_q, w_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic [ADDR_W-1:0] line_addr_q;
    logic [YW-1:0]     next_y_q;
    logic              front_q, urun_q, hb_q, vb_q;
    logic [7:0]        color_q;

    logic [WORD_W-1:0] line_buf [2*WPL];

    logic              frame_ev, first_ev, lend_ev, swap, start, ack, wr_en, last;
    logic [ADDR_W-1:0] start_addr;
    logic [BIDX-1:0]   wr_idx, rd_idx;
    logic [PSH-1:0]    rd_sel;
    logic [WORD_W-1:0] rd_word;

    assign frame_ev   = VBLANK & ~vb_q;
    assign first_ev   = ~VBLANK & vb_q;
    assign lend_ev    = HBLANK & ~hb_q & ~VBLANK;
    // FRAME overrides a coincident LEND; a swap past the last line fetches nothing
    assign swap       = (first_ev | lend_ev) & ~frame_ev;
    assign start      = frame_ev | (swap & (next_y_q != YW'(VLINES)));
    assign start_addr = frame_ev ? BASE : line_addr_q;
    assign ack        = MEM_ACK & (state_q != IDLE);
    assign wr_en      = (state_q == FETCH) & ack & ~start;
    assign last       = (w_q == WIDX'(WPL - 1));

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        addr_d  = addr_q;
        pend_d  = pend_q;
        if (start) begin
            pend_d = start_addr;
            // An un-acked request must be completed before the new line can start
            if (state_q != IDLE && !ack) begin
                state_d = DRAIN;
            end else begin
                state_d = FETCH;
                w_d     = '0;
                addr_d  = start_addr;
            end
        end else begin
            case (state_q)
                FETCH: if (ack) begin
                    if (last) begin
                        state_d = IDLE;
                    end else begin
                        w_d    = w_q + 1'b1;
                        addr_d = addr_q + 1'b1;
                    end
                end
                DRAIN: if (ack) begin
                    state_d = FETCH;
                    w_d     = '0;
                    addr_d  = pend_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK_25MHz) begin
        if (RESET) begin
            state_q     <= IDLE;
            w_q         <= '0;
            addr_q      <= BASE;
            pend_q      <= BASE;
            line_addr_q <= BASE;
            next_y_q    <= '0;
            front_q     <= 1'b0;
            urun_q      <= 1'b0;
            hb_q        <= 1'b1;
            vb_q        <= 1'b1;
            color_q     <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            hb_q    <= HBLANK;
            vb_q    <= VBLANK;
            color_q <= rd_word[{rd_sel, 3'b000} +: 8];
            if (start) line_addr_q <= start_addr + STRIDE;
            if (frame_ev) next_y_q <= '0;
            else if (wr_en && last) next_y_q <= next_y_q + 1'b1;
            if (swap) front_q <= ~front_q;
            if (start && state_q != IDLE) urun_q <= 1'b1;
        end
    end

    assign wr_idx  = (front_q ? BIDX'(0) : BIDX'(WPL)) + BIDX'(w_q);
    assign rd_idx  = (front_q ? BIDX'(WPL) : BIDX'(0)) + BIDX'(CURX >> PSH);
    assign rd_sel  = CURX[PSH-1:0];
    assign rd_word = line_buf[rd_idx];

    always_ff @(posedge CLK_25MHz) begin
        if (wr_en) line_buf[wr_idx] <= MEM_RDATA;
    end

    assign COLOR_DATA_OUT = color_q;
    assign MEM_REQ        = (state_q != IDLE);
    assign MEM_ADDR       = addr_q;
    assign UNDERRUN       = urun_q;

endmodule
